// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store FSM driving a split addr_ok/data_ok bus, with stall, extend, strobes and errors
module mem_access_unit #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] ld_data,
  output logic        addr_err,
  output logic        bus_err,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR, S_BERR} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d, wr_q, wr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        go, mis, cap;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ext;
  always_comb begin
    go  = start & (mem_read | mem_write);
    mis = (mem_size == 2'b01 & addr[0]) | (mem_size[1] & |addr[1:0]);
    lb  = data_rdata[{addr_q[1:0], 3'b000} +: 8];
    lh  = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    ext = size_q == 2'b00 ? {{24{lb[7] & ~uns_q}}, lb} :
          size_q == 2'b01 ? {{16{lh[15] & ~uns_q}}, lh} : data_rdata;
    cap = (state_q == S_REQ & data_addr_ok & data_data_ok) | (state_q == S_WAIT & data_data_ok);
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    ld_d    = cap & ~wr_q ? ext : ld_q;
    case (state_q)
      S_IDLE: if (go) begin
        state_d = mis ? S_ERR : S_REQ;
        if (!mis) begin
          addr_d  = addr;
          wdata_d = wdata;
          size_d  = mem_size;
          uns_d   = mem_unsigned;
          wr_d    = mem_write;
        end
      end
      S_REQ: begin
        state_d = !data_addr_ok ? S_REQ : data_data_ok ? S_DONE : S_WAIT;
        cnt_d   = 8'd0;
      end
      S_WAIT: begin
        state_d = data_data_ok ? S_DONE : cnt_q == 8'(WAIT_LIMIT - 1) ? S_BERR : S_WAIT;
        cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
    end
  end
  assign stall      = (state_q == S_IDLE & go & ~mis) | state_q == S_REQ | state_q == S_WAIT;
  assign done       = state_q == S_DONE;
  assign addr_err   = state_q == S_ERR;
  assign bus_err    = state_q == S_BERR;
  assign data_req   = state_q == S_REQ;
  assign ld_data    = ld_q;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = size_q == 2'b00 ? {4{wdata_q[7:0]}} :
                      size_q == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
  assign data_wstrb = ~wr_q ? 4'b0000 :
                      size_q == 2'b00 ? 4'b0001 << addr_q[1:0] :
                      size_q == 2'b01 ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store engine for the MIPS core.
- Consumes the decoded memory controls (mem_read/mem_write, size, unsigned) together with the EX address and store data.
- Drives an SRAM-like split-handshake data bus. Stalls the pipeline until the access completes.
- Returns sign- or zero-extended load data for lw/lb/lbu/lh/lhu, and byte-lane strobes for sw/sh/sb.

Parameters:
- WAIT_LIMIT, 255: max cycles to wait for data_ok after the address is accepted before flagging bus_err; width of the wait counter is 8 bits.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- start  in  1  memory instruction present in MEM stage this cycle
- mem_read  in  1  load
- mem_write  in  1  store; wins if mem_read is also 1
- mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_unsigned  in  1  zero-extend load (lbu/lhu)
- addr  in  32  effective address
- wdata  in  32  store data (rt)
- stall  out  1  hold pipeline
- done  out  1  one-cycle completion pulse
- ld_data  out  32  extended load result, valid with done on reads
- addr_err  out  1  one-cycle misalignment pulse
- bus_err  out  1  one-cycle timeout pulse
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  copy of latched size
- data_addr  out  32  latched addr
- data_wdata  out  32  lane-replicated store data
- data_wstrb  out  4  byte enables, 0000 on reads
- data_addr_ok  in  1  address accepted
- data_data_ok  in  1  read data returned / write complete
- data_rdata  in  32  read data

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs are 0, including ld_data and the wait counter.
- States and transitions:
  - IDLE, start = 1 with mem_read or mem_write:
    - If misaligned, go to ERR.
    - Otherwise latch addr, wdata, size, unsigned and wr, and go to REQ.
  - IDLE, start = 1 with neither mem_read nor mem_write: ignored.
  - ERR: addr_err = 1 for one cycle, no bus activity, then IDLE.
  - REQ:
    - data_req = 1, bus outputs held stable.
    - data_addr_ok = 0: stay in REQ (no timeout here).
    - data_addr_ok = 1 and data_data_ok = 1 in the same cycle: go to DONE and capture rdata.
    - data_addr_ok = 1 only: go to WAIT and clear the counter.
  - WAIT:
    - data_req = 0.
    - data_data_ok = 1: capture rdata, go to DONE.
    - Otherwise increment the counter. When it reaches WAIT_LIMIT-1 without data_ok, go to BERR.
  - DONE: done = 1 for one cycle, ld_data valid for reads, then IDLE.
  - BERR: bus_err = 1 for one cycle, then IDLE. A late data_ok in IDLE is ignored.
- Misalignment:
  - half with addr[0] = 1 is misaligned.
  - word with addr[1:0] != 00 is misaligned.
  - byte is never misaligned.
- stall (combinational):
  - 1 in IDLE when start = 1 and the access is legal.
  - 1 in REQ and WAIT.
  - 0 in ERR, DONE and BERR.
- Store lanes:
  - byte: wdata = {4{wdata[7:0]}}, wstrb = 0001 << addr[1:0].
  - half: wdata = {2{wdata[15:0]}}, wstrb = 0011 << {addr[1],0}.
  - word: wdata passed through, wstrb = 1111.
- Load extract (from data_rdata, registered into ld_data on capture):
  - byte: lane addr[1:0], extended to 32 bits.
  - half: lane addr[1], extended to 32 bits.
  - Extension is sign unless mem_unsigned = 1, then zero.
  - word: data passed through.
- ld_data holds its value until the next capture.
- Writes still pass through DONE (done = 1), but ld_data is unchanged.
- start while not IDLE is ignored; the pipeline is stalled, so it is the same instruction.
- Reset mid-operation:
  - rst in any state forces IDLE next cycle and drops data_req.
  - No done, addr_err or bus_err pulse is produced.

Test Plan:
1. lw, addr 0x1000, addr_ok in the REQ cycle, data_ok next cycle with rdata 0xDEADBEEF -> stall 1 for 2 cycles, done on cycle 3, ld_data 0xDEADBEEF, wstrb 0000.
2. lb addr 0x2003 then lbu addr 0x2003, rdata 0x80FF_FF7F -> lb ld_data 0xFFFFFF80; lbu 0x00000080; lh addr 0x2002 -> 0xFFFF80FF.
3. sb addr 0x3001 wdata 0x000000AB -> data_wdata 0xABABABAB, wstrb 0010; sh addr 0x3002 wdata 0x1234 -> wdata 0x12341234, wstrb 1100.
4. lw addr 0x1002 -> addr_err one cycle, data_req never 1, stall 0; sh addr 0x1001 -> addr_err likewise.
5. lw with addr_ok held 0 for 5 cycles -> data_req and data_addr stable all 5 cycles; with WAIT_LIMIT = 4 and no data_ok -> bus_err after 4 WAIT cycles, then IDLE.
6. rst asserted in WAIT -> next cycle state IDLE, stall 0, no done; a following data_ok is ignored and a new lw completes normally.
